// File: rtl/pc_sequencer.sv
`default_nettype none
// pc_sequencer: program counter and instruction prefetch buffer; holds issue on jumps
// until resolved, then falls through or flushes and redirects.  Rev 1.0
module pc_sequencer #(
   parameter int              ADDR_W         = 32,
   parameter logic [ADDR_W-1:0] RESET_PC     = '0,
   parameter int              PREFETCH_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_data,
   output logic              cmd_valid,
   output logic [31:0]       cmd,
   output logic [ADDR_W-1:0] cmd_pc,
   input  logic              cmd_ready,
   input  logic              jump_resolve,
   input  logic              should_jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              halt,
   output logic              waiting_resolve
);

   localparam int              PTR_W   = $clog2(PREFETCH_DEPTH);
   localparam int              CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PREFETCH_DEPTH);
   localparam logic [9:0]      JUMP_OP = 10'b0010000000;

   typedef enum logic {F_IDLE = 1'b0, F_REQ = 1'b1} fetch_state_t;
   typedef enum logic {S_RUN = 1'b0, S_WAIT_RESOLVE = 1'b1} issue_state_t;

   fetch_state_t      r_fstate;
   issue_state_t      r_istate;
   logic [31:0]       r_mem_data [PREFETCH_DEPTH];
   logic [ADDR_W-1:0] r_mem_pc   [PREFETCH_DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_imem_addr;
   logic              r_discard;
   logic              r_cmd_valid;
   logic [31:0]       r_cmd;
   logic [ADDR_W-1:0] r_cmd_pc;

   fetch_state_t      w_fstate_nx;
   issue_state_t      w_istate_nx;
   logic              w_ack;
   logic              w_redirect;
   logic              w_push;
   logic              w_pop;
   logic              w_jump_pop;
   logic              w_room;
   logic              w_new_req;
   logic              w_head_fresh;
   logic              w_cmd_valid_nx;
   logic [CNT_W-1:0]  w_count_nx;
   logic [PTR_W-1:0]  w_rd_nx;
   logic [PTR_W-1:0]  w_wr_nx;
   logic [ADDR_W-1:0] w_fetch_pc_nx;

   assign imem_req        = (r_fstate == F_REQ);
   assign imem_addr       = r_imem_addr;
   assign cmd_valid       = r_cmd_valid;
   assign cmd             = r_cmd;
   assign cmd_pc          = r_cmd_pc;
   assign waiting_resolve = (r_istate == S_WAIT_RESOLVE);

   always_comb begin
      w_ack      = (r_fstate == F_REQ) && imem_ack;
      w_redirect = (r_istate == S_WAIT_RESOLVE) && jump_resolve && should_jump;
      // A redirect kills the data acked on the same edge as well as any still in flight.
      w_push     = w_ack && !r_discard && !w_redirect;
      w_pop      = r_cmd_valid && cmd_ready;
      w_jump_pop = w_pop && (r_cmd[31:22] == JUMP_OP);

      w_count_nx = r_count;
      if (w_push) w_count_nx = w_count_nx + CNT_W'(1);
      if (w_pop)  w_count_nx = w_count_nx - CNT_W'(1);
      w_rd_nx = w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
      w_wr_nx = w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
      w_fetch_pc_nx = (w_ack && !r_discard) ? r_fetch_pc + ADDR_W'(1) : r_fetch_pc;
      if (w_redirect) begin
         w_count_nx    = '0;
         w_rd_nx       = '0;
         w_wr_nx       = '0;
         w_fetch_pc_nx = jump_target;
      end

      w_room = !halt && (w_count_nx < DEPTH_C);
      w_fstate_nx = r_fstate;
      case (r_fstate)
         F_IDLE:  w_fstate_nx = w_room ? F_REQ : F_IDLE;
         F_REQ:   w_fstate_nx = (w_ack && !w_room) ? F_IDLE : F_REQ;
         default: w_fstate_nx = F_IDLE;
      endcase
      w_new_req = (w_fstate_nx == F_REQ) && ((r_fstate == F_IDLE) || w_ack);

      w_istate_nx = r_istate;
      case (r_istate)
         S_RUN:          w_istate_nx = w_jump_pop ? S_WAIT_RESOLVE : S_RUN;
         S_WAIT_RESOLVE: w_istate_nx = jump_resolve ? S_RUN : S_WAIT_RESOLVE;
         default:        w_istate_nx = S_RUN;
      endcase

      // Next head comes straight from the ack when it lands in the slot being exposed.
      w_head_fresh   = w_push && (r_wr_ptr == w_rd_nx);
      w_cmd_valid_nx = (w_istate_nx == S_RUN) && (w_count_nx != '0);
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= imem_data;
         r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fstate    <= F_IDLE;
         r_istate    <= S_RUN;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_fetch_pc  <= RESET_PC;
         r_imem_addr <= RESET_PC;
         r_discard   <= 1'b0;
         r_cmd_valid <= 1'b0;
         r_cmd       <= '0;
         r_cmd_pc    <= '0;
      end else begin
         r_fstate   <= w_fstate_nx;
         r_istate   <= w_istate_nx;
         r_rd_ptr   <= w_rd_nx;
         r_wr_ptr   <= w_wr_nx;
         r_count    <= w_count_nx;
         r_fetch_pc <= w_fetch_pc_nx;
         if (w_new_req) r_imem_addr <= w_fetch_pc_nx;
         if (w_redirect && (r_fstate == F_REQ) && !imem_ack) r_discard <= 1'b1;
         else if (w_ack)                                     r_discard <= 1'b0;
         r_cmd_valid <= w_cmd_valid_nx;
         if (w_cmd_valid_nx) begin
            r_cmd    <= w_head_fresh ? imem_data  : r_mem_data[w_rd_nx];
            r_cmd_pc <= w_head_fresh ? r_fetch_pc : r_mem_pc[w_rd_nx];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// tb_pc_sequencer: directed stimulus against a queue-level model of the prefetch/issue rules.
// Rev 1.0
module tb_pc_sequencer;
   localparam logic [31:0] RST_PC = 32'h10;
   localparam int          DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_data = '0;
   logic        cmd_valid;
   logic [31:0] cmd;
   logic [31:0] cmd_pc;
   logic        cmd_ready = 1'b1;
   logic        jump_resolve = 1'b0;
   logic        should_jump = 1'b0;
   logic [31:0] jump_target = '0;
   logic        halt = 1'b0;
   logic        waiting_resolve;

   pc_sequencer #(.ADDR_W(32), .RESET_PC(RST_PC), .PREFETCH_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data), .cmd_valid(cmd_valid), .cmd(cmd),
      .cmd_pc(cmd_pc), .cmd_ready(cmd_ready), .jump_resolve(jump_resolve),
      .should_jump(should_jump), .jump_target(jump_target), .halt(halt),
      .waiting_resolve(waiting_resolve));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Instruction memory contents: one configurable jump location, everything else tagged data.
   logic [31:0] jmp_a = 32'h20;
   function automatic logic [31:0] word(input logic [31:0] a);
      if (a == jmp_a) return 32'h2000_0000;
      return {16'hC0DE, a[15:0]};
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct packed { logic [31:0] d; logic [31:0] a; } ent_t;
   ent_t        q[$];
   ent_t        m_e;
   logic [31:0] m_fetch_pc, m_addr, e_cmd, e_pc;
   bit          m_inflight, m_discard, m_wait, e_valid;
   bit          mk_ack, mk_redir, mk_pop, mk_jmp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_fetch_pc = RST_PC; m_addr = RST_PC;
         m_inflight = 0; m_discard = 0; m_wait = 0;
         e_valid = 0; e_cmd = '0; e_pc = '0;
      end else begin
         mk_ack   = m_inflight && imem_ack;
         mk_redir = m_wait && jump_resolve && should_jump;
         mk_pop   = e_valid && cmd_ready;
         mk_jmp   = mk_pop && (q[0].d[31:22] == 10'b0010000000);
         if (mk_pop) void'(q.pop_front());
         if (mk_ack) begin
            if (!m_discard && !mk_redir) begin
               m_e.d = imem_data; m_e.a = m_addr;
               q.push_back(m_e);
            end
            if (!m_discard) m_fetch_pc = m_fetch_pc + 1;
            m_discard  = 0;
            m_inflight = 0;
         end
         if (mk_redir) begin
            q.delete();
            m_fetch_pc = jump_target;
            if (m_inflight) m_discard = 1;
         end
         if (m_wait && jump_resolve) m_wait = 0;
         else if (mk_jmp)            m_wait = 1;
         if (!m_inflight && !halt && q.size() < DEPTH) begin
            m_inflight = 1;
            m_addr     = m_fetch_pc;
         end
         e_valid = !m_wait && (q.size() != 0);
         if (e_valid) begin
            e_cmd = q[0].d;
            e_pc  = q[0].a;
         end
      end
   end

   // ---------------- compare + memory responder ----------------
   int  ack_lat = 0;
   bit  ack_always = 0;
   int  rsp_cnt = 0;
   int  acc_cnt = 0;

   always @(negedge clk) begin
      chk("imem_req", 32'(imem_req), 32'(m_inflight));
      if (m_inflight) chk("imem_addr", imem_addr, m_addr);
      chk("cmd_valid", 32'(cmd_valid), 32'(e_valid));
      chk("cmd", cmd, e_cmd);
      chk("cmd_pc", cmd_pc, e_pc);
      chk("waiting_resolve", 32'(waiting_resolve), 32'(m_wait));
      if (!rst_n) begin
         imem_ack = 0; rsp_cnt = 0;
      end else if (imem_req) begin
         if (rsp_cnt >= ack_lat) begin
            imem_ack = 1; imem_data = word(imem_addr); rsp_cnt = 0;
         end else begin
            imem_ack = 0; rsp_cnt++;
         end
      end else begin
         imem_ack = ack_always; imem_data = word(imem_addr);
      end
   end

   always @(posedge clk) if (rst_n && imem_req && imem_ack) acc_cnt++;

   // ---------------- directed stimulus ----------------
   task automatic wait_for(input bit want_valid, input int budget, input string nm);
      for (int k = 0; k < budget; k++) begin
         if (want_valid ? cmd_valid : waiting_resolve) break;
         @(negedge clk);
      end
      chk(nm, 32'(want_valid ? cmd_valid : waiting_resolve), 32'd1);
   endtask

   task automatic resolve(input logic sj, input logic [31:0] tgt);
      jump_resolve = 1; should_jump = sj; jump_target = tgt;
      @(negedge clk);
      jump_resolve = 0; should_jump = 0;
   endtask

   int          base;
   logic [31:0] tgt;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_valid", 32'(cmd_valid), 32'd0);
      chk("rst_wait", 32'(waiting_resolve), 32'd0);
      rst_n = 1;
      // 1: back-to-back sequential fetch and issue
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t1_req", 32'(imem_req), 32'd1);
         chk("t1_addr", imem_addr, RST_PC + 32'(i));
         if (i > 0) begin
            chk("t1_valid", 32'(cmd_valid), 32'd1);
            chk("t1_pc", cmd_pc, RST_PC + 32'(i - 1));
         end
      end
      // 3: jump at 0x20 taken to 0x80
      wait_for(0, 200, "t3_wait");
      jmp_a = 32'h84;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_hold_valid", 32'(cmd_valid), 32'd0);
      end
      resolve(1, 32'h80);
      wait_for(1, 50, "t3_valid");
      chk("t3_pc", cmd_pc, 32'h80);
      chk("t3_cmd", cmd, 32'hC0DE_0080);
      // 4: jump at 0x84 not taken
      wait_for(0, 50, "t4_wait");
      ack_lat = 3; jmp_a = 32'h88;
      resolve(0, 32'h300);
      wait_for(1, 50, "t4_valid");
      chk("t4_pc", cmd_pc, 32'h85);
      chk("t4_cmd", cmd, 32'hC0DE_0085);
      // 5: taken jump while a slow fetch is in flight
      wait_for(0, 200, "t5_wait");
      chk("t5_inflight", 32'(imem_req), 32'd1);
      jmp_a = 32'h42;
      resolve(1, 32'h40);
      wait_for(1, 50, "t5_valid");
      chk("t5_pc", cmd_pc, 32'h40);
      ack_lat = 0;
      // redirect to the top of the address space, then wrap
      wait_for(0, 50, "t7_wait");
      jmp_a = 32'h1;
      resolve(1, 32'hFFFF_FFFF);
      wait_for(1, 50, "t7_valid");
      chk("t7_pc", cmd_pc, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("t7_wrap_valid", 32'(cmd_valid), 32'd1);
      chk("t7_wrap_pc", cmd_pc, 32'h0);
      // redirect to the current fetch address still flushes and refetches
      wait_for(0, 50, "t8_wait");
      tgt = m_fetch_pc;
      jmp_a = tgt + 32'd2;
      resolve(1, tgt);
      wait_for(1, 50, "t8_valid");
      chk("t8_pc", cmd_pc, tgt);
      ack_lat = 3;
      // 6: asynchronous reset while waiting on a resolve with a fetch in flight
      wait_for(0, 100, "t6_wait");
      @(posedge clk);
      #3 rst_n = 0;
      #1;
      chk("t6_req", 32'(imem_req), 32'd0);
      chk("t6_addr", imem_addr, RST_PC);
      chk("t6_valid", 32'(cmd_valid), 32'd0);
      chk("t6_cmd", cmd, 32'd0);
      chk("t6_pc", cmd_pc, 32'd0);
      chk("t6_wait_clr", 32'(waiting_resolve), 32'd0);
      ack_lat = 0; ack_always = 1; cmd_ready = 0; jmp_a = 32'hFFFF_0000;
      repeat (2) @(negedge clk);
      rst_n = 1;
      base = acc_cnt;
      // 2: backpressure with ack held high fills exactly DEPTH entries
      repeat (8) @(negedge clk);
      chk("t2_acks", 32'(acc_cnt - base), 32'd2);
      chk("t2_req_off", 32'(imem_req), 32'd0);
      chk("t2_head_pc", cmd_pc, RST_PC);
      cmd_ready = 1;
      @(negedge clk);
      chk("t2_restart", 32'(imem_req), 32'd1);
      // halt stops new requests, issue drains the buffer
      ack_always = 0; halt = 1;
      repeat (10) @(negedge clk);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_drained", 32'(cmd_valid), 32'd0);
      halt = 0;
      repeat (6) @(negedge clk);
      chk("halt_resume", 32'(cmd_valid), 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and instruction-prefetch stage directly upstream of the jump decode/execute path.
- Fetches 32-bit command words from instruction memory into a small prefetch buffer and presents them, with their PC, to the decode stage.
- Detects jump opcodes at issue, holds further issue until the jump decision returns, then either falls through or flushes the buffer and redirects to the jump target.

Parameters:
ADDR_W, 32, instruction address width in words; PC increments by 1 per command.
RESET_PC, 0, PC loaded on reset.
PREFETCH_DEPTH, 2, prefetch buffer entries, power of two, range 2..8.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
imem_req  output  1  fetch request; held high until imem_ack.
imem_addr  output  ADDR_W  fetch address; stable while imem_req is high.
imem_ack  input  1  fetch complete; imem_data valid in the same cycle.
imem_data  input  32  fetched command word.
cmd_valid  output  1  head buffer entry presented to decode.
cmd  output  32  head command word.
cmd_pc  output  ADDR_W  address of the head command.
cmd_ready  input  1  decode accepts the head when cmd_valid is also high.
jump_resolve  input  1  one-cycle pulse: decision for the issued jump is available.
should_jump  input  1  jump decision; qualified by jump_resolve.
jump_target  input  ADDR_W  redirect address; qualified by jump_resolve.
halt  input  1  level; blocks new fetch requests.
waiting_resolve  output  1  high while issue is stalled on a jump decision.

Behaviour:
- Reset (asynchronous, active-low): imem_req=0, imem_addr=RESET_PC, cmd_valid=0, cmd=0, cmd_pc=0, waiting_resolve=0. Buffer empty; fetch_pc=RESET_PC; discard flag clear.
- Fetch FSM, F_IDLE to F_REQ:
  - Moves to F_REQ when not halted and buffer occupancy, counting entries pushed or popped this cycle, is below PREFETCH_DEPTH.
  - In F_REQ, imem_req=1 and imem_addr=fetch_pc.
  - On imem_ack: push {imem_data, fetch_pc} unless discard is set; fetch_pc+1, wrapping modulo 2^ADDR_W.
  - After an ack, stay in F_REQ for back-to-back fetch if room remains; otherwise go to F_IDLE.
  - First request is asserted in the first cycle after rst_n deasserts.
- At most one fetch is in flight. Every pushed entry appears on cmd/cmd_valid the cycle after its ack; there is no combinational imem-to-cmd path.
- Issue FSM, S_RUN and S_WAIT_RESOLVE:
  - In S_RUN, cmd_valid = buffer not empty.
  - A pop occurs when cmd_valid and cmd_ready are both high.
  - If the popped cmd[31:22]==10'b0010000000 (jump op), move to S_WAIT_RESOLVE.
  - In S_WAIT_RESOLVE: waiting_resolve=1 and cmd_valid=0. Fetch continues sequentially, speculatively.
- jump_resolve in S_WAIT_RESOLVE:
  - If should_jump=1: flush the buffer in the same edge and set fetch_pc=jump_target. If a fetch is in flight, set discard; that response is dropped and discard clears on its ack. The target request issues in the cycle after.
  - If should_jump=0: keep the buffer unchanged.
  - Either way, return to S_RUN on that edge.
- jump_resolve while in S_RUN is ignored.
- Simultaneous ack and redirecting jump_resolve: the acked data is dropped and not pushed; the next request uses jump_target.
- Redirect to jump_target == the current fetch_pc still flushes and refetches.
- Pop and push in the same cycle are both honoured, even when the buffer is full at the edge.
- halt does not abort an in-flight request, which completes normally. Issue continues while halted.
- cmd and cmd_pc hold their value while cmd_valid=0.

Test Plan:
1. Reset release, RESET_PC=0x10, imem acks every request in 1 cycle, cmd_ready=1 -> imem_addr sequence 0x10,0x11,0x12; cmd_pc 0x10,0x11,0x12 each one cycle after its ack; no gaps in the steady state.
2. cmd_ready=0, imem_ack always high, DEPTH=2 -> exactly 2 acks accepted, then imem_req=0. Raising cmd_ready restarts fetch the following cycle.
3. Jump word 0x20000000 at PC 0x20, then resolve with should_jump=1, target 0x80 -> waiting_resolve=1 and cmd_valid=0 until resolve; buffer flushed; next issued cmd_pc=0x80.
4. Same jump, resolved with should_jump=0 -> next issued cmd_pc=0x21 with its original data, no refetch.
5. Redirect while a fetch to 0x23 is stalled for 3 cycles -> 0x23 data not issued; imem_addr=0x80 in the cycle after that ack.
6. Assert rst_n=0 mid-fetch and mid-resolve, asynchronously -> all outputs at reset values immediately; after release, first fetch is at RESET_PC.
